// File: rtl/input_acc_sched_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// input_acc_sched_pkg: FSM state type and counter-width helper.
// Rev 1.0
// ------------------------------------------------------------------
package input_acc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } sched_state_e;

  // One extra bit so the counter can hold the value FIFO_DEPTH itself.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_acc_sched_occ_tracker.sv
`default_nettype none
// ------------------------------------------------------------------
// input_acc_occ_tracker: shadow occupancy count and sticky overflow
// flag for one row FIFO. Rev 1.0
// ------------------------------------------------------------------
module input_acc_occ_tracker
  import input_acc_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W = occ_w(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_in,
  input  logic             rd_in,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (wr_in && (count_q == C_FULL)) ovf_d = 1'b1;
    if (wr_in && rd_in) begin
      count_d = count_q;
    end else if (wr_in && (count_q != C_FULL)) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_in) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: rtl/input_acc_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// input_acc_sched: diagonal-skew dequeue sequencer for the row input
// FIFOs. Optional INPUT_ACC_SCHED_PERF_EN adds stall_cycles. Rev 1.0
// ------------------------------------------------------------------
module input_acc_sched
  import input_acc_sched_pkg::*;
#(
  parameter int NUM_ROWS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    vec_len,
  input  logic                hold_in,
  input  logic [NUM_ROWS-1:0] fifo_wr_in,
  output logic [NUM_ROWS-1:0] row_valid_out,
  output logic                busy,
  output logic                done,
  output logic                err_overflow
`ifdef INPUT_ACC_SCHED_PERF_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int CNT_W = occ_w(FIFO_DEPTH);
  localparam int T_W   = LEN_W + $clog2(NUM_ROWS) + 1;

  sched_state_e        state_q, state_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [NUM_ROWS-1:0] row_valid_q, row_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [NUM_ROWS-1:0] active, ready, ovf;
  logic [CNT_W-1:0]    occ [NUM_ROWS];
  logic                issue;
  logic [T_W-1:0]      last_t;

  generate
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      assign active[r] = (t_q >= T_W'(r)) && (t_q < T_W'(r) + T_W'(len_q));
      // Inactive rows never block a step.
      assign ready[r]  = !active[r] || (occ[r] != '0);

      input_acc_occ_tracker #(
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_occ (
        .clk      (clk),
        .rst      (rst),
        .wr_in    (fifo_wr_in[r]),
        .rd_in    (issue && active[r]),
        .count    (occ[r]),
        .overflow (ovf[r])
      );
    end
  endgenerate

  assign issue  = (state_q == ST_STREAM) && !hold_in && (&ready);
  assign last_t = T_W'(len_q) + T_W'(NUM_ROWS) - T_W'(2);

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    len_d       = len_q;
    row_valid_d = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d  = vec_len;
          t_d    = '0;
          busy_d = 1'b1;
          if (vec_len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (issue) begin
          row_valid_d = active;
          if (t_q == last_t) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + T_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      len_q       <= '0;
      row_valid_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      len_q       <= len_d;
      row_valid_q <= row_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign row_valid_out = row_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_overflow  = |ovf;

`ifdef INPUT_ACC_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && start) begin
      stall_d = '0;
    end else if ((state_q == ST_STREAM) && !issue && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_acc_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_input_acc_sched: directed bench with a job-level reference model.
// Rev 1.0
// ------------------------------------------------------------------
module tb_input_acc_sched;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          hold_in = 1'b0;
  logic [LW-1:0] vec_len = '0;
  logic [N-1:0]  fifo_wr_in = '0;
  logic [N-1:0]  row_valid_out;
  logic          busy, done, err_overflow;
`ifdef INPUT_ACC_SCHED_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: phase 0=idle, 1=streaming, 2=done.
  int          m_phase, m_t, m_len;
  int          m_cnt [N];
  logic [31:0] m_stall;
  logic        m_err, m_busy, m_done;
  logic [N-1:0] m_rv;

  // Observed outputs indexed by cycle number relative to a scenario origin.
  int          cnum;
  logic [N-1:0] obs_rv   [64];
  logic         obs_done [64];
  logic         obs_busy [64];
  logic         obs_err  [64];

  always #5 clk = ~clk;

  input_acc_sched #(
    .NUM_ROWS   (N),
    .FIFO_DEPTH (D),
    .LEN_W      (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .vec_len       (vec_len),
    .hold_in       (hold_in),
    .fifo_wr_in    (fifo_wr_in),
    .row_valid_out (row_valid_out),
    .busy          (busy),
    .done          (done),
    .err_overflow  (err_overflow)
`ifdef INPUT_ACC_SCHED_PERF_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_len = 0; m_stall = '0;
    m_err = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rv = '0;
    for (int r = 0; r < N; r++) m_cnt[r] = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] act;
    logic issue, dec;
    act = '0;
    for (int r = 0; r < N; r++)
      if (m_phase == 1 && m_t >= r && m_t < r + m_len) act[r] = 1'b1;
    issue = (m_phase == 1) && !hold_in;
    for (int r = 0; r < N; r++)
      if (act[r] && m_cnt[r] == 0) issue = 1'b0;
    m_rv = issue ? act : '0;
    for (int r = 0; r < N; r++) begin
      dec = issue && act[r];
      if (fifo_wr_in[r] && m_cnt[r] == D) m_err = 1'b1;
      if (fifo_wr_in[r] && dec) m_cnt[r] = m_cnt[r];
      else if (fifo_wr_in[r] && m_cnt[r] < D) m_cnt[r]++;
      else if (dec) m_cnt[r]--;
    end
    case (m_phase)
      0: if (start) begin
           m_len = int'(vec_len); m_t = 0; m_stall = '0;
           m_phase = (m_len == 0) ? 2 : 1;
         end
      1: begin
           if (!issue && m_stall != '1) m_stall = m_stall + 32'd1;
           if (issue) begin
             if (m_t == m_len + N - 2) m_phase = 2;
             else m_t++;
           end
         end
      default: m_phase = 0;
    endcase
    m_busy = (m_phase != 0);
    m_done = (m_phase == 2);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after.
  task automatic tick(input logic st, input int len, input logic hold, input logic [N-1:0] wr);
    start = st; vec_len = LW'(len); hold_in = hold; fifo_wr_in = wr;
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    chk("row_valid_out", 64'(row_valid_out), 64'(m_rv));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("err_overflow", 64'(err_overflow), 64'(m_err));
`ifdef INPUT_ACC_SCHED_PERF_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
    if (cnum + 1 < 64) begin
      obs_rv[cnum+1]   = row_valid_out;
      obs_done[cnum+1] = done;
      obs_busy[cnum+1] = busy;
      obs_err[cnum+1]  = err_overflow;
    end
    cnum++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0, '0);
  endtask

  task automatic preload(input int n, input logic [N-1:0] wr);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0, wr);
  endtask

  initial begin
    model_reset();
    cnum = 0;
    idle(2);
    chk("reset row_valid_out", 64'(row_valid_out), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset err_overflow", 64'(err_overflow), 64'd0);
    rst = 1'b1;
    idle(1);

    // Full preload, L=3, no stalls.
    preload(3, 2'b11);
    cnum = 0;
    tick(1'b1, 3, 1'b0, '0);
    idle(6);
    chk("s1 rv c2", 64'(obs_rv[2]), 64'h1);
    chk("s1 rv c3", 64'(obs_rv[3]), 64'h3);
    chk("s1 rv c4", 64'(obs_rv[4]), 64'h3);
    chk("s1 rv c5", 64'(obs_rv[5]), 64'h2);
    chk("s1 done c5", 64'(obs_done[5]), 64'h1);
    chk("s1 done c4", 64'(obs_done[4]), 64'h0);
    chk("s1 cnt0", 64'(m_cnt[0]), 64'd0);
    chk("s1 cnt1", 64'(m_cnt[1]), 64'd0);

    // Row1 empty: step 1 stalls until row1 writes arrive in cycles 6..8.
    preload(3, 2'b01);
    cnum = 0;
    tick(1'b1, 3, 1'b0, '0);
    idle(5);
    preload(3, 2'b10);
    idle(4);
    chk("s2 rv c2", 64'(obs_rv[2]), 64'h1);
    chk("s2 rv c7", 64'(obs_rv[7]), 64'h0);
    chk("s2 rv c8", 64'(obs_rv[8]), 64'h3);
    chk("s2 rv c9", 64'(obs_rv[9]), 64'h3);
    chk("s2 rv c10", 64'(obs_rv[10]), 64'h2);
    chk("s2 done c10", 64'(obs_done[10]), 64'h1);
`ifdef INPUT_ACC_SCHED_PERF_EN
    chk("s2 stall_cycles", 64'(stall_cycles), 64'd5);
`endif

    // hold_in during cycles 1..2 pushes everything two cycles later.
    preload(3, 2'b11);
    cnum = 0;
    tick(1'b1, 3, 1'b0, '0);
    tick(1'b0, 0, 1'b1, '0);
    tick(1'b0, 0, 1'b1, '0);
    idle(7);
    chk("s3 rv c2", 64'(obs_rv[2]), 64'h0);
    chk("s3 rv c4", 64'(obs_rv[4]), 64'h1);
    chk("s3 rv c5", 64'(obs_rv[5]), 64'h3);
    chk("s3 rv c7", 64'(obs_rv[7]), 64'h2);
    chk("s3 done c7", 64'(obs_done[7]), 64'h1);

    // L=0, plus a start in cycle 1 that must be ignored.
    cnum = 0;
    tick(1'b1, 0, 1'b0, '0);
    tick(1'b1, 5, 1'b0, '0);
    idle(3);
    chk("s4 done c1", 64'(obs_done[1]), 64'h1);
    chk("s4 busy c1", 64'(obs_busy[1]), 64'h1);
    chk("s4 busy c2", 64'(obs_busy[2]), 64'h0);
    chk("s4 done c2", 64'(obs_done[2]), 64'h0);
    chk("s4 rv c3", 64'(obs_rv[3]), 64'h0);

    // Overflow: fifth write to row0 while full.
    cnum = 0;
    preload(5, 2'b01);
    chk("s5 err after 4", 64'(obs_err[4]), 64'h0);
    chk("s5 err after 5", 64'(obs_err[5]), 64'h1);
    chk("s5 cnt0", 64'(m_cnt[0]), 64'd4);
    preload(1, 2'b10);
    cnum = 0;
    tick(1'b1, 1, 1'b0, '0);
    idle(4);
    chk("s5 rv c2", 64'(obs_rv[2]), 64'h1);
    chk("s5 rv c3", 64'(obs_rv[3]), 64'h2);
    chk("s5 done c3", 64'(obs_done[3]), 64'h1);
    chk("s5 err sticky", 64'(err_overflow), 64'h1);

    // Asynchronous reset in cycle 3 of a run.
    preload(3, 2'b10);
    cnum = 0;
    tick(1'b1, 3, 1'b0, '0);
    tick(1'b0, 0, 1'b0, '0);
    tick(1'b0, 0, 1'b0, '0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("s6 async rv", 64'(row_valid_out), 64'h0);
    chk("s6 async busy", 64'(busy), 64'h0);
    chk("s6 async done", 64'(done), 64'h0);
    chk("s6 async err", 64'(err_overflow), 64'h0);
    idle(2);
    rst = 1'b1;
    idle(1);
    preload(3, 2'b11);
    cnum = 0;
    tick(1'b1, 3, 1'b0, '0);
    idle(6);
    chk("s6 rv c2", 64'(obs_rv[2]), 64'h1);
    chk("s6 rv c3", 64'(obs_rv[3]), 64'h3);
    chk("s6 rv c5", 64'(obs_rv[5]), 64'h2);
    chk("s6 done c5", 64'(obs_done[5]), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
